// File: rtl/rca_seq_pkg.sv
// Shared definitions for the multi-word ripple-carry sequencer.
// The FSM state encoding is kept here so that the top and any future users agree on it.
package rca_seq_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/ripple_carry_adder_n_bit.sv
// Purely combinational WIDTH-bit ripple-carry adder built from a chain of full adders.
module ripple_carry_adder_n_bit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/rca_multiword_sequencer.sv
// Multi-precision adder: one shared WIDTH-bit adder walks N_WORDS words LSW first,
// chaining the carry through carry_reg, with valid/ready handshakes on both sides.
module rca_multiword_sequencer
  import rca_seq_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int N_WORDS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_valid,
  output logic                       start_ready,
  input  logic [WIDTH*N_WORDS-1:0]   a,
  input  logic [WIDTH*N_WORDS-1:0]   b,
  input  logic                       cin,
  output logic [WIDTH*N_WORDS-1:0]   sum,
  output logic                       cout,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic                       busy
);

  localparam int TW    = WIDTH * N_WORDS;
  localparam int IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [TW-1:0]    a_reg;
  logic [TW-1:0]    b_reg;
  logic             carry_reg;

  logic [WIDTH-1:0] word_a;
  logic [WIDTH-1:0] word_b;
  logic [WIDTH-1:0] word_sum;
  logic             word_cout;
  logic             accept;

  // start_ready must drop during reset itself, so it is derived from state and rst.
  assign start_ready = (state == S_IDLE) && !rst;
  assign busy        = (state != S_IDLE);
  assign accept      = start_valid && start_ready;

  assign word_a = a_reg[WIDTH*idx +: WIDTH];
  assign word_b = b_reg[WIDTH*idx +: WIDTH];

  ripple_carry_adder_n_bit #(.WIDTH(WIDTH)) u_adder (
    .a    (word_a),
    .b    (word_b),
    .cin  (carry_reg),
    .sum  (word_sum),
    .cout (word_cout)
  );

  // Operand capture: only loaded on an accepted start, so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_reg <= a;
      b_reg <= b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      carry_reg <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_valid) begin
            carry_reg <= cin;
            idx       <= '0;
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          sum[WIDTH*idx +: WIDTH] <= word_sum;
          carry_reg               <= word_cout;
          idx                     <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            cout      <= word_cout;
            res_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rca_multiword_sequencer.sv
// Directed bench for rca_multiword_sequencer (WIDTH=4, N_WORDS=4).
module tb_rca_multiword_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic [15:0] sum;
  logic        cout;
  logic        res_valid;
  logic        res_ready;
  logic        busy;

  int checks = 0;
  int errors = 0;

  rca_multiword_sequencer #(.WIDTH(4), .N_WORDS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .sum         (sum),
    .cout        (cout),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One complete handshake from IDLE; inputs are scrambled during RUN on purpose.
  task automatic do_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                       input logic tcin, input logic [15:0] exp_sum, input logic exp_cout);
    chk({tag, "_ready"}, 32'(start_ready), 32'd1);
    a = ta; b = tb_; cin = tcin; start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    a = ~ta; b = ~tb_; cin = ~tcin;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    step(); step(); step();
    chk({tag, "_early"}, 32'(res_valid), 32'd0);
    step();
    chk({tag, "_valid"}, 32'(res_valid), 32'd1);
    chk({tag, "_sum"}, 32'(sum), 32'(exp_sum));
    chk({tag, "_cout"}, 32'(cout), 32'(exp_cout));
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk({tag, "_clear"}, 32'(res_valid), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [16:0] expv;
    logic [15:0] hold_sum;
    logic        hold_cout;

    rst = 1'b1; start_valid = 1'b0; res_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    step(); step();
    chk("rst_ready", 32'(start_ready), 32'd0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step();

    do_op("t1", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);
    do_op("t2", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    do_op("t3a", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0);
    do_op("t3b", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
    do_op("t3c", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);

    // Backpressure in DONE with a competing start request.
    a = 16'h8001; b = 16'h7FFF; cin = 1'b1; start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    step(); step(); step(); step();
    chk("t4_valid0", 32'(res_valid), 32'd1);
    chk("t4_sum0", 32'(sum), 32'h0001);
    chk("t4_cout0", 32'(cout), 32'd1);
    hold_sum = 16'h0001; hold_cout = 1'b1;
    start_valid = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_valid", 32'(res_valid), 32'd1);
      chk("t4_sum", 32'(sum), 32'(hold_sum));
      chk("t4_cout", 32'(cout), 32'(hold_cout));
      chk("t4_ready", 32'(start_ready), 32'd0);
    end
    start_valid = 1'b0;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("t4_release", 32'(res_valid), 32'd0);
    chk("t4_idle", 32'(busy), 32'd0);

    // Abort during the second RUN cycle.
    a = 16'hFFFF; b = 16'h0001; cin = 1'b0; start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_valid", 32'(res_valid), 32'd0);
    chk("t5_sum", 32'(sum), 32'd0);
    chk("t5_cout", 32'(cout), 32'd0);
    chk("t5_ready_in_rst", 32'(start_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("t5_ready", 32'(start_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t5_novalid", 32'(res_valid), 32'd0);
    end

    // Streaming: start_valid and res_ready held high, one accept every 6 edges.
    start_valid = 1'b1;
    res_ready = 1'b1;
    for (int n = 0; n < 200; n++) begin
      chk("t6_ready", 32'(start_ready), 32'd1);
      a = 16'($urandom);
      b = 16'($urandom);
      cin = 1'($urandom_range(0, 1));
      expv = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      step();
      chk("t6_busy", 32'(busy), 32'd1);
      a = 16'($urandom);
      b = 16'($urandom);
      cin = ~cin;
      step(); step(); step();
      chk("t6_early", 32'(res_valid), 32'd0);
      step();
      chk("t6_valid", 32'(res_valid), 32'd1);
      chk("t6_sum", 32'(sum), 32'(expv[15:0]));
      chk("t6_cout", 32'(cout), 32'(expv[16]));
      step();
    end
    start_valid = 1'b0;
    res_ready = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
